// File: rtl/pcie_rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// pcie_rx_sync_ctrl
//
// Per-lane receive symbol-lock controller placed directly after the PCIe
// 10b-to-8b decoder. It closes the running-disparity loop back into the
// decoder, runs a comma-based lock state machine with error hysteresis,
// forwards decoded symbols downstream only while locked, and keeps a
// saturating count of errored symbols.
//
// Ports:
//   clk           symbol clock
//   rst           asynchronous active-high reset
//   sym_valid     decoder outputs valid this cycle
//   dec_data      decoder data_out
//   dec_datak     decoder datak_out
//   dec_disp_out  decoder running disparity after the symbol
//   dec_disp_err  decoder disparity error
//   dec_code_err  decoder code error
//   cnt_clr       synchronous clear of err_cnt (acts on valid symbols)
//   rd_out        registered running disparity, drives decoder disp_in (0 = RD-)
//   sync_ok       lane locked
//   state_out     00 LOS, 01 ACQ, 10 SYNC
//   out_valid     forwarded symbol valid
//   out_data      forwarded symbol data
//   out_datak     forwarded K flag
//   out_err       forwarded symbol had a code or disparity error
//   err_cnt       saturating count of errored symbols
//
// Optional feature macro: PCIEXP_SKP_DROP_EN
//   When defined, clean K28.0 (SKP) symbols received while locked are not
//   forwarded. They still update rd_out and still count as clean symbols
//   for the bad-symbol hysteresis.
// ---------------------------------------------------------------------------
module pcie_rx_sync_ctrl #(
    parameter int COMMA_CNT = 4,
    parameter int BAD_MAX   = 4,
    parameter int GOOD_RUN  = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sym_valid,
    input  logic [7:0]           dec_data,
    input  logic                 dec_datak,
    input  logic                 dec_disp_out,
    input  logic                 dec_disp_err,
    input  logic                 dec_code_err,
    input  logic                 cnt_clr,
    output logic                 rd_out,
    output logic                 sync_ok,
    output logic [1:0]           state_out,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_datak,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_LOS  = 2'b00,
        ST_ACQ  = 2'b01,
        ST_SYNC = 2'b10
    } state_t;

    localparam logic [3:0] COMMA_LIM = 4'(COMMA_CNT);
    localparam logic [3:0] BAD_LIM   = 4'(BAD_MAX);
    localparam logic [3:0] GOOD_LIM  = 4'(GOOD_RUN);

    state_t     state;
    logic [3:0] comma_cnt;
    logic [3:0] bad_cnt;
    logic [3:0] good_cnt;

    logic err;
    logic comma;
    logic fwd;

    // Saturating increment: the statistic sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    assign err   = dec_code_err | dec_disp_err;
    assign comma = dec_datak & (dec_data == 8'hBC) & ~err;

    // Forwarding decision uses the state before this symbol's update, so the
    // comma that completes acquisition is not forwarded while the error that
    // breaks lock still is.
`ifdef PCIEXP_SKP_DROP_EN
    logic skp;
    assign skp = dec_datak & (dec_data == 8'h1C) & ~err;
    assign fwd = (state == ST_SYNC) & ~skp;
`else
    assign fwd = (state == ST_SYNC);
`endif

    assign state_out = state;

    // Stage boundary: decoder outputs -> registered lock state and forwarded symbol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOS;
            comma_cnt <= 4'd0;
            bad_cnt   <= 4'd0;
            good_cnt  <= 4'd0;
            rd_out    <= 1'b0;
            sync_ok   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_datak <= 1'b0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (sym_valid) begin
                // Disparity follows every symbol, errored or not, in all states.
                rd_out    <= dec_disp_out;
                out_valid <= fwd;
                out_data  <= dec_data;
                out_datak <= dec_datak;
                out_err   <= err;

                if (cnt_clr)
                    err_cnt <= err ? ERR_CNT_W'(1) : '0;
                else if (err)
                    err_cnt <= sat_inc(err_cnt);

                case (state)
                    ST_LOS: begin
                        if (comma) begin
                            state     <= ST_ACQ;
                            comma_cnt <= 4'd1;
                        end
                    end

                    ST_ACQ: begin
                        if (err) begin
                            state     <= ST_LOS;
                            comma_cnt <= 4'd0;
                        end else if (comma) begin
                            comma_cnt <= comma_cnt + 4'd1;
                            if (comma_cnt + 4'd1 == COMMA_LIM) begin
                                state    <= ST_SYNC;
                                sync_ok  <= 1'b1;
                                bad_cnt  <= 4'd0;
                                good_cnt <= 4'd0;
                            end
                        end
                    end

                    ST_SYNC: begin
                        if (err) begin
                            good_cnt <= 4'd0;
                            if (bad_cnt + 4'd1 == BAD_LIM) begin
                                state     <= ST_LOS;
                                sync_ok   <= 1'b0;
                                comma_cnt <= 4'd0;
                                bad_cnt   <= 4'd0;
                            end else begin
                                bad_cnt <= bad_cnt + 4'd1;
                            end
                        end else begin
                            // A full run of clean symbols pays back one bad-symbol credit.
                            if (good_cnt + 4'd1 == GOOD_LIM) begin
                                good_cnt <= 4'd0;
                                if (bad_cnt != 4'd0)
                                    bad_cnt <= bad_cnt - 4'd1;
                            end else begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end
                    end

                    default: begin
                        state     <= ST_LOS;
                        sync_ok   <= 1'b0;
                        comma_cnt <= 4'd0;
                        bad_cnt   <= 4'd0;
                        good_cnt  <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcie_rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pcie_rx_sync_ctrl
//
// Self-checking bench for pcie_rx_sync_ctrl. Directed sequences walk through
// acquisition, forwarding, error hysteresis, counter saturation, SKP handling
// and asynchronous reset; a randomized phase follows. A behavioural model of
// the lane lock rules predicts every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_pcie_rx_sync_ctrl;

    localparam int COMMA_CNT = 4;
    localparam int BAD_MAX   = 4;
    localparam int GOOD_RUN  = 4;
    localparam int ERR_CNT_W = 4;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

`ifdef PCIEXP_SKP_DROP_EN
    localparam bit SKP_DROP = 1'b1;
`else
    localparam bit SKP_DROP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sym_valid;
    logic [7:0]           dec_data;
    logic                 dec_datak;
    logic                 dec_disp_out;
    logic                 dec_disp_err;
    logic                 dec_code_err;
    logic                 cnt_clr;
    logic                 rd_out;
    logic                 sync_ok;
    logic [1:0]           state_out;
    logic                 out_valid;
    logic [7:0]           out_data;
    logic                 out_datak;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    pcie_rx_sync_ctrl #(
        .COMMA_CNT (COMMA_CNT),
        .BAD_MAX   (BAD_MAX),
        .GOOD_RUN  (GOOD_RUN),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sym_valid    (sym_valid),
        .dec_data     (dec_data),
        .dec_datak    (dec_datak),
        .dec_disp_out (dec_disp_out),
        .dec_disp_err (dec_disp_err),
        .dec_code_err (dec_code_err),
        .cnt_clr      (cnt_clr),
        .rd_out       (rd_out),
        .sync_ok      (sync_ok),
        .state_out    (state_out),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_datak    (out_datak),
        .out_err      (out_err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Lock mode as text-level concept: 0 = lost, 1 = acquiring, 2 = locked.
    int       m_mode;
    int       m_commas;
    int       m_bad;
    int       m_good;
    int       m_errs;
    bit       m_rd;
    bit       m_ov;
    bit [7:0] m_od;
    bit       m_ok;
    bit       m_oe;

    task automatic model_reset();
        m_mode = 0; m_commas = 0; m_bad = 0; m_good = 0; m_errs = 0;
        m_rd = 0; m_ov = 0; m_od = 0; m_ok = 0; m_oe = 0;
    endtask

    task automatic model_step(input bit v, input bit [7:0] d, input bit k, input bit disp,
                              input bit de, input bit ce, input bit clr);
        bit e, is_comma, is_skp;
        if (!v) begin
            m_ov = 0;
            return;
        end
        e        = de | ce;
        is_comma = k && (d == 8'hBC) && !e;
        is_skp   = k && (d == 8'h1C) && !e;
        m_rd = disp;
        m_ov = (m_mode == 2) && !(SKP_DROP && is_skp);
        m_od = d; m_ok = k; m_oe = e;
        if (clr)    m_errs = e ? 1 : 0;
        else if (e) m_errs = (m_errs + 1 > CNT_MAX) ? CNT_MAX : m_errs + 1;

        if (m_mode == 0) begin
            if (is_comma) begin m_mode = 1; m_commas = 1; end
        end else if (m_mode == 1) begin
            if (e) begin
                m_mode = 0; m_commas = 0;
            end else if (is_comma) begin
                m_commas++;
                if (m_commas == COMMA_CNT) begin m_mode = 2; m_bad = 0; m_good = 0; end
            end
        end else begin
            if (e) begin
                m_good = 0;
                m_bad++;
                if (m_bad == BAD_MAX) begin m_mode = 0; m_commas = 0; m_bad = 0; end
            end else begin
                m_good++;
                if (m_good == GOOD_RUN) begin
                    m_good = 0;
                    if (m_bad > 0) m_bad--;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("state",   32'(state_out), 32'(m_mode));
        check("sync_ok", 32'(sync_ok),   32'(m_mode == 2));
        check("rd_out",  32'(rd_out),    32'(m_rd));
        check("valid",   32'(out_valid), 32'(m_ov));
        check("err_cnt", 32'(err_cnt),   32'(m_errs));
        if (m_ov) begin
            check("data",  32'(out_data),  32'(m_od));
            check("datak", 32'(out_datak), 32'(m_ok));
            check("oerr",  32'(out_err),   32'(m_oe));
        end
    endtask

    // Drive one cycle of decoder output, clock it, then compare #1 after the edge.
    task automatic send(input bit v, input bit [7:0] d, input bit k, input bit disp,
                        input bit de, input bit ce, input bit clr);
        sym_valid = v; dec_data = d; dec_datak = k; dec_disp_out = disp;
        dec_disp_err = de; dec_code_err = ce; cnt_clr = clr;
        @(posedge clk);
        model_step(v, d, k, disp, de, ce, clr);
        #1;
        compare_all();
    endtask

    task automatic send_comma(input bit disp);
        send(1, 8'hBC, 1, disp, 0, 0, 0);
    endtask

    task automatic send_clean(input bit [7:0] d);
        send(1, d, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic send_err();
        send(1, 8'h55, 0, 1'b1, 0, 1, 0);
    endtask

    int fwd_seen;

    initial begin
        rst = 1'b1;
        sym_valid = 0; dec_data = 0; dec_datak = 0; dec_disp_out = 0;
        dec_disp_err = 0; dec_code_err = 0; cnt_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",   32'(state_out), 32'd0);
        check("rst_sync",    32'(sync_ok),   32'd0);
        check("rst_rd",      32'(rd_out),    32'd0);
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_errcnt",  32'(err_cnt),   32'd0);
        check("rst_data",    32'(out_data),  32'd0);
        rst = 1'b0;

        // 1: four clean commas with alternating disparity reach lock.
        send_comma(1); check("t1_s1", 32'(state_out), 32'd1);
        send_comma(0); check("t1_rd2", 32'(rd_out), 32'd0);
        send_comma(1);
        send_comma(0);
        check("t1_sync", 32'(sync_ok), 32'd1);
        check("t1_nofwd", 32'(out_valid), 32'd0);

        // 2: data symbol forwarded one cycle later.
        send_clean(8'hB5);
        check("t2_data", 32'(out_data), 32'hB5);
        check("t2_valid", 32'(out_valid), 32'd1);

        // 4: spaced errors are absorbed, a burst breaks lock.
        for (int r = 0; r < 3; r++) begin
            send_err();
            for (int i = 0; i < GOOD_RUN; i++) send_clean(8'(8'h10 + i));
        end
        check("t4_held", 32'(sync_ok), 32'd1);
        for (int i = 0; i < BAD_MAX; i++) send_err();
        check("t4_los", 32'(state_out), 32'd0);
        check("t4_fwd_err", 32'(out_valid & out_err), 32'd1);

        // 3: error during acquisition restarts it from scratch.
        send_comma(1);
        send_comma(0);
        send(1, 8'hBC, 1, 1'b1, 0, 1, 0);
        check("t3_los", 32'(state_out), 32'd0);
        for (int i = 0; i < COMMA_CNT - 1; i++) send_comma(i[0]);
        check("t3_notyet", 32'(sync_ok), 32'd0);
        send_comma(1);
        check("t3_sync", 32'(sync_ok), 32'd1);

        // 5: saturation then clear-with-error.
        for (int i = 0; i < CNT_MAX + 2; i++) send_err();
        check("t5_sat", 32'(err_cnt), 32'hF);
        send(1, 8'h00, 0, 1'b0, 1, 0, 1);
        check("t5_clr_err", 32'(err_cnt), 32'd1);
        send(1, 8'h00, 0, 1'b0, 0, 0, 1);
        check("t5_clr", 32'(err_cnt), 32'd0);

        // 6: COM, SKP x3, D0.0 while locked.
        for (int i = 0; i < COMMA_CNT; i++) send_comma(i[0]);
        fwd_seen = 0;
        send(1, 8'hBC, 1, 1'b1, 0, 0, 0); fwd_seen += int'(out_valid);
        for (int i = 0; i < 3; i++) begin
            send(1, 8'h1C, 1, i[0], 0, 0, 0); fwd_seen += int'(out_valid);
        end
        send(1, 8'h00, 0, 1'b0, 0, 0, 0); fwd_seen += int'(out_valid);
        check("t6_fwd_cnt", 32'(fwd_seen), SKP_DROP ? 32'd2 : 32'd5);

        // Idle cycle: out_valid drops, everything else holds.
        send(0, 8'hBC, 1, 1'b1, 1, 1, 1);

        // Asynchronous reset while locked takes effect before the next edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state_out), 32'd0);
        check("arst_sync",  32'(sync_ok),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            bit       v, k, disp, de, ce, clr;
            bit [7:0] d;
            int       r;
            v = ($urandom_range(0, 99) < 85);
            r = $urandom_range(0, 99);
            if (r < 35)      begin d = 8'hBC; k = 1; end
            else if (r < 45) begin d = 8'h1C; k = 1; end
            else begin
                d = 8'($urandom);
                k = ($urandom_range(0, 9) == 0);
            end
            disp = 1'($urandom);
            ce   = ($urandom_range(0, 99) < 6);
            de   = ($urandom_range(0, 99) < 4);
            clr  = ($urandom_range(0, 99) < 3);
            send(v, d, k, disp, de, ce, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
